// File: rtl/dds_wavegen.sv
// Purpose: direct digital synthesis core with a byte-wide, double-buffered register port.
//          Modes are sine, saw, triangle and square, with optional inversion.
// Latency: 2 enabled cycles from an accumulator value to its wave_out/sync_out sample.
// Backpressure: none. ena=0 freezes the accumulator and pipeline, and sync_out drops to 0.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   ena                   advance accumulator and pipeline
//   wr_en/wr_addr/wr_data staging register byte write
//   commit                copy staging to active (and optionally clear the accumulator)
//   wave_out/out_valid    offset-binary sample and its valid flag
//   sync_out              one-cycle pulse on the sample whose accumulator step wrapped
module dds_wavegen #(
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 12,
    parameter int LUT_AW = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             commit,
    output logic [OUT_W-1:0] wave_out,
    output logic             out_valid,
    output logic             sync_out
);
    localparam int NBYTE = ACC_W / 8;
    localparam int NLUT  = 1 << LUT_AW;
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
    // pi/2 in Q30 fixed point
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    typedef enum logic [1:0] {
        MODE_SINE = 2'd0,
        MODE_SAW  = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_SQR  = 2'd3
    } mode_t;

    // Quarter-wave table entry round((mid-1)*sin(pi/2*(i+0.5)/2^LUT_AW)).
    // It is evaluated only with constant arguments, so it elaborates to a ROM.
    // A Q30 Taylor series keeps the error far below the rounding step.
    function automatic logic [OUT_W-2:0] lut_val(input int idx);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint amp;
        x    = (HALF_PI_Q30 * longint'(2 * idx + 1)) >>> (LUT_AW + 1);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 10; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        amp = (sum * longint'((1 << (OUT_W - 1)) - 1) + (longint'(1) <<< 29)) >>> 30;
        return amp[OUT_W-2:0];
    endfunction

    logic [OUT_W-2:0] lut [NLUT];
    for (genvar g = 0; g < NLUT; g++) begin : g_lut
        assign lut[g] = lut_val(g);
    end

    // ---------------- staging / active registers ----------------
    logic [ACC_W-1:0] tune_stg_q, tune_act_q;
    logic [15:0]      off_stg_q, off_act_q;
    mode_t            mode_stg_q, mode_act_q;
    logic             inv_stg_q, inv_act_q, clr_stg_q;

    // Commit reads the staging values before this edge's write lands,
    // so a same-cycle write is held back for the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tune_stg_q <= '0;
            off_stg_q  <= '0;
            mode_stg_q <= MODE_SINE;
            inv_stg_q  <= 1'b0;
            clr_stg_q  <= 1'b0;
            tune_act_q <= '0;
            off_act_q  <= '0;
            mode_act_q <= MODE_SINE;
            inv_act_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                // Tuning bytes above the accumulator width have no register.
                for (int b = 0; b < NBYTE; b++) begin
                    if (wr_addr == 3'(b)) begin
                        tune_stg_q[8*b +: 8] <= wr_data;
                    end
                end
                case (wr_addr)
                    3'd4: off_stg_q[7:0]  <= wr_data;
                    3'd5: off_stg_q[15:8] <= wr_data;
                    3'd6: begin
                        mode_stg_q <= mode_t'(wr_data[1:0]);
                        inv_stg_q  <= wr_data[2];
                    end
                    3'd7: clr_stg_q <= wr_data[0];
                    default: ;
                endcase
            end
            if (commit) begin
                tune_act_q <= tune_stg_q;
                off_act_q  <= off_stg_q;
                mode_act_q <= mode_stg_q;
                inv_act_q  <= inv_stg_q;
            end
        end
    end

    // ---------------- S0: accumulator ----------------
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             wrap0_q, wrap0_d;
    logic [ACC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, tune_act_q};

    always_comb begin
        acc_d   = acc_q;
        wrap0_d = wrap0_q;
        if (commit && clr_stg_q) begin
            acc_d   = '0;
            wrap0_d = 1'b0;
        end else if (ena) begin
            acc_d   = acc_sum[ACC_W-1:0];
            wrap0_d = acc_sum[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            wrap0_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            wrap0_q <= wrap0_d;
        end
    end

    // ---------------- S1: phase add and quadrant decode ----------------
    logic [15:0]       phase_d;
    logic [LUT_AW-1:0] idx_raw, idx_d;
    logic [15:0]       phase1_q;
    logic [LUT_AW-1:0] idx1_q;
    mode_t             mode1_q;
    logic              inv1_q, wrap1_q, vld1_q;

    assign phase_d = acc_q[ACC_W-1 -: 16] + off_act_q;
    assign idx_raw = phase_d[13 -: LUT_AW];
    // Odd quadrants read the table backwards.
    assign idx_d   = phase_d[14] ? ~idx_raw : idx_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase1_q <= '0;
            idx1_q   <= '0;
            mode1_q  <= MODE_SINE;
            inv1_q   <= 1'b0;
            wrap1_q  <= 1'b0;
            vld1_q   <= 1'b0;
        end else if (ena) begin
            phase1_q <= phase_d;
            idx1_q   <= idx_d;
            mode1_q  <= mode_act_q;
            inv1_q   <= inv_act_q;
            wrap1_q  <= wrap0_q;
            vld1_q   <= 1'b1;
        end
    end

    // ---------------- S2: waveform compute ----------------
    logic [OUT_W-1:0] sample_d;
    logic [OUT_W-2:0] lut_sel;
    logic [15:0]      tri_w;

    always_comb begin
        sample_d = '0;
        tri_w    = '0;
        lut_sel  = lut[idx1_q];
        case (mode1_q)
            MODE_SINE: begin
                if (phase1_q[15]) begin
                    sample_d = MID - OUT_W'(1) - {1'b0, lut_sel};
                end else begin
                    sample_d = MID + {1'b0, lut_sel};
                end
            end
            MODE_SAW: sample_d = phase1_q[15 -: OUT_W];
            MODE_TRI: begin
                tri_w    = {phase1_q[14:0], 1'b0} ^ {16{phase1_q[15]}};
                sample_d = tri_w[15 -: OUT_W];
            end
            default: sample_d = {OUT_W{~phase1_q[15]}};
        endcase
        if (inv1_q) begin
            sample_d = ~sample_d;
        end
    end

    logic [OUT_W-1:0] wave_q;
    logic             sync_q, valid_q;

    // wave_out keeps its reset value until S1 holds a real sample.
    // sync_q is forced low while stalled so a pulse is never stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_q  <= '0;
            sync_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (ena) begin
            valid_q <= vld1_q;
            if (vld1_q) begin
                wave_q <= sample_d;
                sync_q <= wrap1_q;
            end
        end else begin
            sync_q <= 1'b0;
        end
    end

    assign wave_out  = wave_q;
    assign sync_out  = sync_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_dds_wavegen.sv
`timescale 1ns/1ps
module tb_dds_wavegen;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 12;
    localparam int LUT_AW = 6;
    localparam int NLUT   = 1 << LUT_AW;
    localparam int MID    = 1 << (OUT_W - 1);
    localparam int MAXV   = (1 << OUT_W) - 1;
    localparam longint unsigned MODV = 64'd1 << ACC_W;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             ena     = 1'b0;
    logic             wr_en   = 1'b0;
    logic [2:0]       wr_addr = 3'd0;
    logic [7:0]       wr_data = 8'd0;
    logic             commit  = 1'b0;
    logic [OUT_W-1:0] wave_out;
    logic             out_valid;
    logic             sync_out;

    dds_wavegen #(.ACC_W(ACC_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .commit    (commit),
        .wave_out  (wave_out),
        .out_valid (out_valid),
        .sync_out  (sync_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wave;
        bit sync;
    } exp_t;

    exp_t expq[$];
    int   hist[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   en_cnt;
    bit   exp_valid;
    int   last_exp = 0;

    // Reference model state: staging and active register sets plus accumulator.
    longint unsigned m_acc, st_tune, a_tune;
    int st_off, a_off, st_mode, a_mode;
    bit st_inv, a_inv, st_clr;

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    // Sample for a given accumulator value and active settings, straight from the waveform rules.
    function automatic int ref_sample(longint unsigned acc, int off, int mode, bit inv);
        int  p, i, s, t, lv;
        real ang;
        p = (int'(acc >> (ACC_W - 16)) + off) % 65536;
        case (mode)
            0: begin
                i = (p >> (14 - LUT_AW)) % NLUT;
                if (((p >> 14) & 1) == 1) i = NLUT - 1 - i;
                ang = 3.14159265358979 / 2.0 * (real'(i) + 0.5) / real'(NLUT);
                lv  = $rtoi($floor(real'(MID - 1) * $sin(ang) + 0.5));
                s   = (p < 32768) ? MID + lv : MID - 1 - lv;
            end
            1: s = p >> (16 - OUT_W);
            2: begin
                t = (p * 2) % 65536;
                if (p >= 32768) t = 65535 - t;
                s = t >> (16 - OUT_W);
            end
            default: s = (p < 32768) ? MAXV : 0;
        endcase
        if (inv) s = MAXV - s;
        return s;
    endfunction

    task automatic model_reset();
        exp_t e;
        m_acc = 0; st_tune = 0; a_tune = 0;
        st_off = 0; a_off = 0; st_mode = 0; a_mode = 0;
        st_inv = 0; a_inv = 0; st_clr = 0;
        en_cnt = 0; exp_valid = 0;
        expq.delete();
        e.wave = ref_sample(0, 0, 0, 1'b0);
        e.sync = 1'b0;
        expq.push_back(e);
    endtask

    // One clock edge of the reference model, using the inputs present at the edge.
    task automatic model_step();
        longint unsigned sum;
        bit   wrap;
        exp_t e;
        if (!rst_n) return;
        wrap = 1'b0;
        if (commit && st_clr) begin
            m_acc = 0;
        end else if (ena) begin
            sum   = m_acc + a_tune;
            wrap  = (sum >= MODV);
            m_acc = sum % MODV;
        end
        if (commit) begin
            a_tune = st_tune; a_off = st_off; a_mode = st_mode; a_inv = st_inv;
        end
        if (wr_en) begin
            if (int'(wr_addr) < ACC_W / 8) begin
                st_tune = (st_tune & ~(64'hFF << (8 * wr_addr))) | (longint'(wr_data) << (8 * wr_addr));
            end
            case (wr_addr)
                3'd4: st_off = (st_off & 32'hFF00) | int'(wr_data);
                3'd5: st_off = (st_off & 32'h00FF) | (int'(wr_data) << 8);
                3'd6: begin st_mode = int'(wr_data) % 4; st_inv = wr_data[2]; end
                3'd7: st_clr = wr_data[0];
                default: ;
            endcase
        end
        if (ena) begin
            en_cnt++;
            e.wave = ref_sample(m_acc, a_off, a_mode, a_inv);
            e.sync = wrap;
            expq.push_back(e);
        end
        exp_valid = (en_cnt >= 2);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    // Commit with ena high; returns the hist index of the sample of the commit-edge accumulator.
    task automatic do_commit(output int mark);
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        mark = hist.size() + 1;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        logic en_s;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                chk("rst_wave", wave_out, 0);
                chk("rst_valid", out_valid, 0);
                chk("rst_sync", sync_out, 0);
            end else begin
                en_s = ena;
                #1;
                chk("out_valid", out_valid, exp_valid);
                if (!exp_valid) begin
                    chk("idle_wave", wave_out, 0);
                    chk("idle_sync", sync_out, 0);
                end else if (en_s) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL scoreboard_empty at %0t: got sample %0d, expected none", $time, wave_out);
                    end else begin
                        e = expq.pop_front();
                        chk("wave", wave_out, e.wave);
                        chk("sync", sync_out, e.sync);
                        last_exp = e.wave;
                        hist.push_back(int'(wave_out));
                    end
                end else begin
                    chk("hold_wave", wave_out, last_exp);
                    chk("hold_sync", sync_out, 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int mark, mark2;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cyc();

        // Saw, tune 0x010000
        wr(3'd0, 8'h00); wr(3'd1, 8'h00); wr(3'd2, 8'h01); wr(3'd6, 8'h01);
        ena = 1'b1;
        do_commit(mark);
        repeat (600) cyc();

        // Square, tune 0x100000
        wr(3'd2, 8'h10); wr(3'd6, 8'h03);
        do_commit(mark);
        repeat (64) cyc();

        // Sine, tune 0x040000, phase cleared on commit
        wr(3'd2, 8'h04); wr(3'd6, 8'h00); wr(3'd7, 8'h01);
        do_commit(mark);
        repeat (70) cyc();
        chk("sine_k0", hist[mark], ref_sample(0, 0, 0, 1'b0));
        for (int k = 0; k < 32; k++) begin
            chk("sine_half_period", hist[mark + k + 32], MAXV - hist[mark + k]);
        end

        // Saw with offset 0x8000 and phase clear; square written during the commit cycle
        wr(3'd4, 8'h00); wr(3'd5, 8'h80); wr(3'd6, 8'h01);
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h03;
        do_commit(mark);
        wr_en = 1'b0;
        repeat (10) cyc();
        chk("clr_saw_mid", hist[mark], MID);
        do_commit(mark2);
        repeat (20) cyc();
        chk("wr_commit_next", hist[mark2], 0);

        // Saw without clear, then ena low for 5 cycles
        wr(3'd7, 8'h00); wr(3'd4, 8'h00); wr(3'd5, 8'h00); wr(3'd6, 8'h01);
        do_commit(mark);
        repeat (30) cyc();
        ena = 1'b0;
        repeat (5) cyc();
        ena = 1'b1;
        repeat (30) cyc();

        // tune=0: constant output, no sync
        wr(3'd0, 8'h00); wr(3'd1, 8'h00); wr(3'd2, 8'h00);
        do_commit(mark);
        repeat (30) cyc();

        // tune=2^(ACC_W-1): sync every 2nd sample
        wr(3'd2, 8'h80);
        do_commit(mark);
        repeat (20) cyc();

        // Inverted triangle
        wr(3'd2, 8'h02); wr(3'd6, 8'h06);
        do_commit(mark);
        repeat (300) cyc();

        // Randomised writes, stalls and commits
        for (int n = 0; n < 400; n++) begin
            ena     = ($urandom_range(0, 3) != 0);
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom);
            commit  = ena && ($urandom_range(0, 15) == 0);
            cyc();
        end
        wr_en = 1'b0; commit = 1'b0; ena = 1'b1;
        repeat (20) cyc();

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        model_reset();
        ena = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc();
        ena = 1'b1;
        repeat (8) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
